pit_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single PIT register-bank slave port between a host CPU master (m0) and a DMA/sequencer master (m1). It sits between both masters and the PIT bus interface. It grants the slave port round-robin, holds the grant for the whole `cyc` period, and muxes address, data and control to the slave. A watchdog ends any cycle the slave never acknowledges and returns an error to the stalled master.

---
 rtl/pit_wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_pit_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pit_wb_arbiter.sv
// pit_wb_arbiter: round-robin two-master Wishbone arbiter in front of the PIT
// register-bank slave. A grant is held for a whole cyc period. A watchdog ends
// any strobe the slave never acknowledges and returns err to the stalled master.
module pit_wb_arbiter #(
  parameter int DWIDTH   = 16,
  parameter int TO_WIDTH = 4
) (
  input  logic              wb_clk_i,
  input  logic              arst_i,
  input  logic              wb_rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [2:0]        m0_adr_i,
  input  logic [DWIDTH-1:0] m0_dat_i,
  input  logic [1:0]        m0_sel_i,
  output logic [DWIDTH-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [2:0]        m1_adr_i,
  input  logic [DWIDTH-1:0] m1_dat_i,
  input  logic [1:0]        m1_sel_i,
  output logic [DWIDTH-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [2:0]        s_adr_o,
  output logic [DWIDTH-1:0] s_dat_o,
  output logic [1:0]        s_sel_o,
  input  logic [DWIDTH-1:0] s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  // The counter holds completed unacknowledged strobe cycles, so the strobe
  // cycle seen with cnt_q == 2**TO_WIDTH-2 is the (2**TO_WIDTH-1)-th one.
  localparam logic [TO_WIDTH-1:0] TO_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

  logic [1:0]          state_q, state_d;
  logic                last_q, last_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  logic g0, g1, gnt, gi;
  logic cyc_g, stb_g, oth_cyc, timeout;

  assign g0      = (state_q == GNT0);
  assign g1      = (state_q == GNT1);
  assign gnt     = g0 | g1;
  assign gi      = g1;
  assign cyc_g   = gi ? m1_cyc_i : m0_cyc_i;
  assign stb_g   = gi ? m1_stb_i : m0_stb_i;
  assign oth_cyc = gi ? m0_cyc_i : m1_cyc_i;
  // an ack in the same cycle beats the watchdog
  assign timeout = gnt & stb_g & ~s_ack_i & (cnt_q == TO_LAST);

  // next-state: arbitration, release/handoff, watchdog counting
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (timeout) begin
          last_d  = gi;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!cyc_g) begin
          last_d  = gi;
          cnt_d   = '0;
          state_d = oth_cyc ? (gi ? GNT0 : GNT1) : IDLE;
        end else if (s_ack_i) begin
          cnt_d = '0;
        end else if (stb_g) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state registers; async and sync reset have the same effect
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // slave-side mux, all zero when idle; watchdog kills cyc/stb on timeout
  always_comb begin
    s_cyc_o = gnt & ~timeout & cyc_g;
    s_stb_o = gnt & ~timeout & stb_g;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (g0) begin
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (g1) begin
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  // master-side responses; a sync reset in progress suppresses ack/err
  always_comb begin
    m0_ack_o = s_ack_i & g0 & m0_stb_i & ~wb_rst_i;
    m1_ack_o = s_ack_i & g1 & m1_stb_i & ~wb_rst_i;
    m0_err_o = timeout & g0 & ~wb_rst_i;
    m1_err_o = timeout & g1 & ~wb_rst_i;
    m0_dat_o = g0 ? s_dat_i : '0;
    m1_dat_o = g1 ? s_dat_i : '0;
    gnt_o    = {g1, g0};
  end

endmodule

// File: tb/tb_pit_wb_arbiter.sv
// tb_pit_wb_arbiter: directed test-plan scenarios followed by randomized
// traffic, every cycle compared against an ownership/wait-count model.
module tb_pit_wb_arbiter;

  localparam int DW    = 16;
  localparam int TOW   = 4;
  localparam int LIMIT = (1 << TOW) - 1;

  logic          wb_clk_i = 1'b0;
  logic          arst_i, wb_rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [2:0]    m0_adr_i, m1_adr_i;
  logic [DW-1:0] m0_dat_i, m1_dat_i;
  logic [1:0]    m0_sel_i, m1_sel_i;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [2:0]    s_adr_o;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic [1:0]    s_sel_o, gnt_o;
  logic          s_ack_i;

  int n_chk = 0;
  int n_err = 0;

  // model: who owns the slave (-1 none), who was served last, and how many
  // strobe cycles the owner has waited without an ack
  int own, lst, waited;
  bit to_now;

  pit_wb_arbiter #(.DWIDTH(DW), .TO_WIDTH(TOW)) dut (
    .wb_clk_i(wb_clk_i), .arst_i(arst_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    own = -1; lst = 1; waited = 0;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0; m0_sel_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0; m1_sel_i = 0;
    s_ack_i = 0; s_dat_i = 0; wb_rst_i = 0;
  endtask

  // wait to mid-cycle and compare every output with the model
  task automatic sample();
    logic cyc_n, stb_n;
    logic [23:0] e_s;
    logic [DW+1:0] e_m0, e_m1;
    @(negedge wb_clk_i);
    cyc_n = (own == 1) ? m1_cyc_i : m0_cyc_i;
    stb_n = (own == 1) ? m1_stb_i : m0_stb_i;
    to_now = (own >= 0) && stb_n && !s_ack_i && (waited + 1 == LIMIT);
    if (own == 0)      e_s = {cyc_n & !to_now, stb_n & !to_now, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i};
    else if (own == 1) e_s = {cyc_n & !to_now, stb_n & !to_now, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i};
    else               e_s = '0;
    e_m0 = {s_ack_i && own == 0 && m0_stb_i && !wb_rst_i, to_now && own == 0 && !wb_rst_i,
            (own == 0) ? s_dat_i : {DW{1'b0}}};
    e_m1 = {s_ack_i && own == 1 && m1_stb_i && !wb_rst_i, to_now && own == 1 && !wb_rst_i,
            (own == 1) ? s_dat_i : {DW{1'b0}}};
    chk("gnt", gnt_o, {own == 1, own == 0});
    chk("slave", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}, e_s);
    chk("m0_rsp", {m0_ack_o, m0_err_o, m0_dat_o}, e_m0);
    chk("m1_rsp", {m1_ack_o, m1_err_o, m1_dat_o}, e_m1);
  endtask

  // apply the arbitration rules to the model, then move to the next cycle
  task automatic adv();
    logic cyc_n, stb_n, oth;
    cyc_n = (own == 1) ? m1_cyc_i : m0_cyc_i;
    stb_n = (own == 1) ? m1_stb_i : m0_stb_i;
    oth   = (own == 1) ? m0_cyc_i : m1_cyc_i;
    if (wb_rst_i) mdl_reset();
    else if (own < 0) begin
      if (m0_cyc_i && m1_cyc_i) own = (lst == 1) ? 0 : 1;
      else if (m0_cyc_i) own = 0;
      else if (m1_cyc_i) own = 1;
      waited = 0;
    end else if (to_now) begin
      lst = own; own = -1; waited = 0;
    end else if (!cyc_n) begin
      lst = own; own = oth ? 1 - own : -1; waited = 0;
    end else if (s_ack_i) waited = 0;
    else if (stb_n) waited++;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic tick();
    sample(); adv();
  endtask

  task automatic pulse_areset();
    arst_i = 0; #2; arst_i = 1;
    mdl_reset();
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    idle_inputs();
    arst_i = 0;
    mdl_reset();
    #12;
    // reset state
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_slave", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}, 24'h0);
    arst_i = 1;
    @(posedge wb_clk_i); #1;

    // single read from m0
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 3'd1; m0_sel_i = 2'b11;
    tick();
    sample(); chk("rd_gnt", gnt_o, 2'b01); adv();
    tick();
    s_ack_i = 1; s_dat_i = 16'hA5C3;
    sample(); chk("rd_ack", m0_ack_o, 1'b1); chk("rd_dat", m0_dat_o, 16'hA5C3);
    chk("rd_m1ack", m1_ack_o, 1'b0); adv();
    idle_inputs();
    tick(); tick();

    // simultaneous requests out of reset
    pulse_areset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 3'd5; m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 3'd2;
    tick();
    sample(); chk("sim_gnt0", gnt_o, 2'b01); chk("sim_adr0", s_adr_o, 3'd5); adv();
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    sample(); chk("sim_hand", gnt_o, 2'b10); chk("sim_adr1", s_adr_o, 3'd2); adv();
    m1_cyc_i = 0; m1_stb_i = 0;
    tick();
    m0_cyc_i = 1; m1_cyc_i = 1;
    tick();
    sample(); chk("sim_rr", gnt_o, 2'b01); adv();
    idle_inputs();
    tick();

    // m1 holds cyc across three write beats while m0 waits
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
    for (int b = 0; b < 3; b++) begin
      m1_adr_i = 3'(b); m1_dat_i = 16'($urandom);
      sample();
      chk("b2b_gnt", gnt_o, 2'b10); chk("b2b_adr", s_adr_o, 3'(b)); chk("b2b_dat", s_dat_o, m1_dat_i);
      adv();
    end
    m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
    tick();
    sample(); chk("b2b_m0", gnt_o, 2'b01); adv();
    idle_inputs();
    tick();

    // watchdog timeout with m1 pending
    pulse_areset();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    for (int i = 1; i <= LIMIT; i++) begin
      sample();
      chk("to_err", m0_err_o, (i == LIMIT) ? 1'b1 : 1'b0);
      if (i == LIMIT) chk("to_stb", s_stb_o, 1'b0);
      adv();
    end
    sample(); chk("to_idle", gnt_o, 2'b00); adv();
    sample(); chk("to_m1", gnt_o, 2'b10); adv();
    idle_inputs();
    tick();

    // ack lands on the timeout cycle
    pulse_areset();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    for (int i = 1; i < LIMIT; i++) tick();
    s_ack_i = 1;
    sample(); chk("ato_ack", m0_ack_o, 1'b1); chk("ato_err", m0_err_o, 1'b0); adv();
    s_ack_i = 0;
    sample(); chk("ato_hold", gnt_o, 2'b01); adv();
    idle_inputs();
    tick();

    // async reset in the middle of an m1 cycle
    m1_cyc_i = 1; m1_stb_i = 1;
    tick(); tick();
    s_ack_i = 1;
    #2 arst_i = 0;
    #1;
    chk("ar_cyc", s_cyc_o, 1'b0); chk("ar_gnt", gnt_o, 2'b00);
    chk("ar_rsp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0);
    mdl_reset();
    @(posedge wb_clk_i); #1;
    arst_i = 1; s_ack_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    sample(); chk("ar_first", gnt_o, 2'b01); adv();
    idle_inputs();
    tick();

    // sync reset in the middle of an m1 cycle
    m1_cyc_i = 1; m1_stb_i = 1;
    tick(); tick();
    wb_rst_i = 1;
    sample(); chk("sr_before", gnt_o, 2'b10); adv();
    wb_rst_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
    sample(); chk("sr_after", gnt_o, 2'b00); adv();
    sample(); chk("sr_first", gnt_o, 2'b01); adv();
    idle_inputs();
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 5) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i & ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i & ($urandom_range(0, 3) != 0);
      m0_we_i = 1'($urandom); m0_adr_i = 3'($urandom); m0_dat_i = 16'($urandom); m0_sel_i = 2'($urandom);
      m1_we_i = 1'($urandom); m1_adr_i = 3'($urandom); m1_dat_i = 16'($urandom); m1_sel_i = 2'($urandom);
      s_dat_i = 16'($urandom);
      s_ack_i = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      wb_rst_i = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
